// File: rtl/usb4_ll_pkg.sv
// Shared constants for the USB4 lane link core: state codes, config
// register addresses and default link symbols.
package usb4_ll_pkg;

    // Link state codes, also reported in STATUS[2:0]
    localparam logic [2:0] ST_DISABLED     = 3'd0;
    localparam logic [2:0] ST_SB_CONNECT   = 3'd1;
    localparam logic [2:0] ST_SB_HANDSHAKE = 3'd2;
    localparam logic [2:0] ST_TRAINING     = 3'd3;
    localparam logic [2:0] ST_CL0          = 3'd4;

    // Config word addresses
    localparam logic [7:0] ADDR_CAP       = 8'h00;
    localparam logic [7:0] ADDR_LANE_CTRL = 8'h01;
    localparam logic [7:0] ADDR_STATUS    = 8'h02;

    // Default link symbols and capability value
    localparam logic [7:0]  TS_BYTE_DEF = 8'h4B;
    localparam logic [7:0]  HS_BYTE_DEF = 8'hA5;
    localparam logic [31:0] GEN_CAP_DEF = 32'h0000_0007;

    // Layout of the STATUS register payload
    typedef struct packed {
        logic [4:0] train_cnt;
        logic [2:0] state;
    } status_t;

    // Lanes carry data only while training or in CL0
    function automatic logic is_lane_active(input logic [2:0] st);
        return (st == ST_TRAINING) || (st == ST_CL0);
    endfunction

endpackage

// File: rtl/usb4_lane_link_core_sb_uart.sv
// Sideband UART: 1 start, 8 data LSB first, 1 stop, SB_DIV cycles per bit.
// The receiver expects an already-synchronised line.
module sb_uart #(
    parameter int SB_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       tx_busy,
    output logic       tx_line,
    input  logic       rx_line,
    output logic       rx_valid,
    output logic [7:0] rx_byte
);
    localparam int DW = $clog2(SB_DIV) + 1;
    localparam logic [DW-1:0] DIV_LAST  = DW'(SB_DIV - 1);
    localparam logic [DW-1:0] HALF_LAST = DW'(SB_DIV / 2 - 1);

    logic          tx_busy_r;
    logic          tx_line_r;
    logic [9:0]    tx_sh_r;
    logic [3:0]    tx_bit_r;
    logic [DW-1:0] tx_div_r;

    logic          rx_prev_r;
    logic          rx_busy_r;
    logic [DW-1:0] rx_cnt_r;
    logic [3:0]    rx_bit_r;
    logic [7:0]    rx_sh_r;
    logic          rx_valid_r;
    logic [7:0]    rx_byte_r;

    // Transmitter: load a frame when idle, shift one bit every SB_DIV cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_busy_r <= 1'b0;
            tx_line_r <= 1'b1;
            tx_sh_r   <= 10'h3FF;
            tx_bit_r  <= 4'd0;
            tx_div_r  <= '0;
        end else if (!tx_busy_r) begin
            if (tx_start) begin
                tx_busy_r <= 1'b1;
                tx_sh_r   <= {1'b1, tx_byte, 1'b0};
                tx_line_r <= 1'b0;
                tx_bit_r  <= 4'd0;
                tx_div_r  <= '0;
            end
        end else if (tx_div_r == DIV_LAST) begin
            tx_div_r <= '0;
            if (tx_bit_r == 4'd9) begin
                tx_busy_r <= 1'b0;
                tx_line_r <= 1'b1;
            end else begin
                tx_bit_r  <= tx_bit_r + 4'd1;
                tx_sh_r   <= {1'b1, tx_sh_r[9:1]};
                tx_line_r <= tx_sh_r[1];
            end
        end else begin
            tx_div_r <= tx_div_r + 1'b1;
        end
    end

    // Receiver: falling edge starts a frame, sample mid-bit, validate start/stop
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_prev_r  <= 1'b1;
            rx_busy_r  <= 1'b0;
            rx_cnt_r   <= '0;
            rx_bit_r   <= 4'd0;
            rx_sh_r    <= 8'd0;
            rx_valid_r <= 1'b0;
            rx_byte_r  <= 8'd0;
        end else begin
            rx_valid_r <= 1'b0;
            rx_prev_r  <= rx_line;
            if (!rx_busy_r) begin
                if (rx_prev_r && !rx_line) begin
                    rx_busy_r <= 1'b1;
                    rx_cnt_r  <= HALF_LAST;
                    rx_bit_r  <= 4'd0;
                end
            end else if (rx_cnt_r != '0) begin
                rx_cnt_r <= rx_cnt_r - 1'b1;
            end else begin
                rx_cnt_r <= DIV_LAST;
                if (rx_bit_r == 4'd0) begin
                    // a high line at mid start bit was a glitch
                    if (rx_line) begin
                        rx_busy_r <= 1'b0;
                    end else begin
                        rx_bit_r <= 4'd1;
                    end
                end else if (rx_bit_r == 4'd9) begin
                    rx_busy_r <= 1'b0;
                    if (rx_line) begin
                        rx_valid_r <= 1'b1;
                        rx_byte_r  <= rx_sh_r;
                    end
                end else begin
                    rx_sh_r  <= {rx_line, rx_sh_r[7:1]};
                    rx_bit_r <= rx_bit_r + 4'd1;
                end
            end
        end
    end

    assign tx_busy  = tx_busy_r;
    assign tx_line  = tx_line_r;
    assign rx_valid = rx_valid_r;
    assign rx_byte  = rx_byte_r;

endmodule

// File: rtl/usb4_lane_link_core.sv
// USB4 logical-layer lane core (no scrambler): config registers, link
// bring-up FSM, two-lane serializer and deserializer.
module usb4_lane_link_core
    import usb4_ll_pkg::*;
#(
    parameter int          SB_DIV         = 16,
    parameter int          CONNECT_CYCLES = 32,
    parameter int          DISC_CYCLES    = 256,
    parameter int          TRAIN_LEN      = 8,
    parameter logic [7:0]  TS_BYTE        = TS_BYTE_DEF,
    parameter logic [7:0]  HS_BYTE        = HS_BYTE_DEF,
    parameter logic [31:0] GEN_CAP        = GEN_CAP_DEF
) (
    input  logic        local_clk,
    input  logic        rst,
    input  logic        lane_disable,
    input  logic        c_read,
    input  logic        c_write,
    input  logic [7:0]  c_address,
    input  logic [31:0] c_data_in,
    output logic [31:0] c_data_out,
    input  logic [7:0]  transport_layer_data_in,
    output logic [7:0]  transport_layer_data_out,
    input  logic        lane_0_rx_i,
    input  logic        lane_1_rx_i,
    input  logic        enable_deser,
    input  logic        sbrx,
    output logic        sbtx,
    output logic        lane_0_tx_o,
    output logic        lane_1_tx_o,
    output logic        enable_scr
);
    logic [2:0]  state_r, state_nxt;
    logic [31:0] ctrl_r, rd_data_s, c_data_out_r;
    logic        sbrx_m_r, sbrx_s_r;
    logic [15:0] conn_cnt_r, disc_cnt_r;
    logic        hs_got_r, tx_start_s, tx_busy_s, tx_line_s, rx_valid_s;
    logic [7:0]  rx_byte_s;
    logic        sbtx_r, lane0_r, lane1_r, enable_scr_r;
    logic [1:0]  ph_r, dph_r;
    logic [7:0]  tx_byte_r, src_s, cur_byte_s, ts_sent_r;
    logic [7:0]  dsh_r, dsh_nxt_s, word_r, tl_out_r;
    logic        done_r, entry_s;
    logic [4:0]  train_cnt_r;
    status_t     status_s;

    sb_uart #(.SB_DIV(SB_DIV)) u_sb (
        .clk(local_clk), .rst(rst),
        .tx_start(tx_start_s), .tx_byte(HS_BYTE),
        .tx_busy(tx_busy_s), .tx_line(tx_line_s),
        .rx_line(sbrx_s_r), .rx_valid(rx_valid_s), .rx_byte(rx_byte_s)
    );

    assign status_s   = '{train_cnt: train_cnt_r, state: state_r};
    assign tx_start_s = (state_r == ST_SB_HANDSHAKE) && !hs_got_r && !tx_busy_s;
    assign entry_s    = (state_nxt == ST_TRAINING) && (state_r != ST_TRAINING);
    assign dsh_nxt_s  = {lane_1_rx_i, lane_0_rx_i, dsh_r[7:2]};

    // Config read data mux
    always_comb begin
        rd_data_s = 32'd0;
        case (c_address)
            ADDR_CAP:       rd_data_s = GEN_CAP;
            ADDR_LANE_CTRL: rd_data_s = ctrl_r;
            ADDR_STATUS:    rd_data_s = {24'd0, status_s};
            default:        rd_data_s = 32'd0;
        endcase
    end

    // Link state transitions; disable wins, then sideband disconnect
    always_comb begin
        state_nxt = state_r;
        if (lane_disable || !ctrl_r[0]) begin
            state_nxt = ST_DISABLED;
        end else if ((state_r == ST_SB_HANDSHAKE || is_lane_active(state_r)) &&
                     !sbrx_s_r && (disc_cnt_r == 16'(DISC_CYCLES - 1))) begin
            state_nxt = ST_SB_CONNECT;
        end else begin
            case (state_r)
                ST_DISABLED:     state_nxt = ST_SB_CONNECT;
                ST_SB_CONNECT:   state_nxt = (sbrx_s_r && conn_cnt_r == 16'(CONNECT_CYCLES - 1)) ?
                                             ST_SB_HANDSHAKE : ST_SB_CONNECT;
                ST_SB_HANDSHAKE: state_nxt = (hs_got_r && !tx_busy_s) ? ST_TRAINING : ST_SB_HANDSHAKE;
                ST_TRAINING:     state_nxt = (train_cnt_r >= 5'(TRAIN_LEN) && ts_sent_r >= 8'(TRAIN_LEN)) ?
                                             ST_CL0 : ST_TRAINING;
                ST_CL0:          state_nxt = ST_CL0;
                default:         state_nxt = ST_DISABLED;
            endcase
        end
    end

    // Transmit byte source and the byte being shifted this phase
    always_comb begin
        src_s      = (state_r == ST_TRAINING) ? TS_BYTE : transport_layer_data_in;
        cur_byte_s = (ph_r == 2'd0) ? src_s : tx_byte_r;
    end

    // State register, config registers and sideband synchronizer
    always_ff @(posedge local_clk) begin
        if (rst) begin
            state_r      <= ST_DISABLED;
            ctrl_r       <= 32'd0;
            c_data_out_r <= 32'd0;
            sbrx_m_r     <= 1'b0;
            sbrx_s_r     <= 1'b0;
        end else begin
            state_r  <= state_nxt;
            sbrx_m_r <= sbrx;
            sbrx_s_r <= sbrx_m_r;
            if (c_read) c_data_out_r <= rd_data_s;
            if (c_write && c_address == ADDR_LANE_CTRL) ctrl_r <= c_data_in;
        end
    end

    // Connect/disconnect run-length counters and handshake receipt flag
    always_ff @(posedge local_clk) begin
        if (rst) begin
            conn_cnt_r <= 16'd0;
            disc_cnt_r <= 16'd0;
            hs_got_r   <= 1'b0;
        end else begin
            conn_cnt_r <= (state_r == ST_SB_CONNECT && sbrx_s_r) ? conn_cnt_r + 16'd1 : 16'd0;
            disc_cnt_r <= ((state_r == ST_SB_HANDSHAKE || is_lane_active(state_r)) && !sbrx_s_r) ?
                          disc_cnt_r + 16'd1 : 16'd0;
            if (state_r == ST_SB_HANDSHAKE) begin
                if (rx_valid_s && rx_byte_s == HS_BYTE) hs_got_r <= 1'b1;
            end else begin
                hs_got_r <= 1'b0;
            end
        end
    end

    // Registered sideband, lane and scrambler-enable outputs, lane serializer
    always_ff @(posedge local_clk) begin
        if (rst) begin
            sbtx_r       <= 1'b0;
            enable_scr_r <= 1'b0;
            lane0_r      <= 1'b0;
            lane1_r      <= 1'b0;
            ph_r         <= 2'd0;
            tx_byte_r    <= 8'd0;
            ts_sent_r    <= 8'd0;
        end else begin
            case (state_nxt)
                ST_DISABLED:   sbtx_r <= 1'b0;
                ST_SB_CONNECT: sbtx_r <= 1'b1;
                default:       sbtx_r <= tx_line_s;
            endcase
            enable_scr_r <= (state_nxt == ST_CL0);
            ph_r         <= ph_r + 2'd1;
            if (ph_r == 2'd0) tx_byte_r <= src_s;
            if (is_lane_active(state_r) && is_lane_active(state_nxt)) begin
                lane0_r <= cur_byte_s[{ph_r, 1'b0}];
                lane1_r <= cur_byte_s[{ph_r, 1'b1}];
            end else begin
                lane0_r <= 1'b0;
                lane1_r <= 1'b0;
            end
            if (state_r == ST_TRAINING) begin
                if (ph_r == 2'd0 && ts_sent_r < 8'(TRAIN_LEN)) ts_sent_r <= ts_sent_r + 8'd1;
            end else begin
                ts_sent_r <= 8'd0;
            end
        end
    end

    // Deserializer: qualified pairs shift in, a byte completes every 4 pairs
    always_ff @(posedge local_clk) begin
        if (rst) begin
            dph_r  <= 2'd0;
            dsh_r  <= 8'd0;
            word_r <= 8'd0;
            done_r <= 1'b0;
        end else if (entry_s) begin
            dph_r  <= 2'd0;
            done_r <= 1'b0;
        end else if (enable_deser) begin
            dsh_r  <= dsh_nxt_s;
            dph_r  <= dph_r + 2'd1;
            done_r <= (dph_r == 2'd3);
            if (dph_r == 2'd3) word_r <= dsh_nxt_s;
        end else begin
            done_r <= 1'b0;
        end
    end

    // Training match counter and received-byte output register
    always_ff @(posedge local_clk) begin
        if (rst) begin
            train_cnt_r <= 5'd0;
            tl_out_r    <= 8'd0;
        end else begin
            if (entry_s) begin
                train_cnt_r <= 5'd0;
            end else if (state_r == ST_TRAINING && done_r) begin
                if (word_r != TS_BYTE)          train_cnt_r <= 5'd0;
                else if (train_cnt_r != 5'd31)  train_cnt_r <= train_cnt_r + 5'd1;
            end
            if (state_r == ST_TRAINING)          tl_out_r <= 8'd0;
            else if (state_r == ST_CL0 && done_r) tl_out_r <= word_r;
        end
    end

    assign c_data_out               = c_data_out_r;
    assign transport_layer_data_out = tl_out_r;
    assign sbtx                     = sbtx_r;
    assign lane_0_tx_o              = lane0_r;
    assign lane_1_tx_o              = lane1_r;
    assign enable_scr               = enable_scr_r;

endmodule

// File: tb/tb_usb4_lane_link_core.sv
// Directed bench for usb4_lane_link_core: config access, sideband bring-up,
// training, CL0 data in both directions, disable and disconnect.
module tb_usb4_lane_link_core;
    logic        clk = 1'b0;
    logic        rst, lane_disable, c_read, c_write;
    logic [7:0]  c_address;
    logic [31:0] c_data_in, c_data_out;
    logic [7:0]  tl_in, tl_out;
    logic        l0_rx, l1_rx, enable_deser, sbrx, sbtx, l0_tx, l1_tx, enable_scr;

    int n_checks = 0;
    int n_pass   = 0;

    usb4_lane_link_core dut (
        .local_clk(clk), .rst(rst), .lane_disable(lane_disable),
        .c_read(c_read), .c_write(c_write), .c_address(c_address),
        .c_data_in(c_data_in), .c_data_out(c_data_out),
        .transport_layer_data_in(tl_in), .transport_layer_data_out(tl_out),
        .lane_0_rx_i(l0_rx), .lane_1_rx_i(l1_rx), .enable_deser(enable_deser),
        .sbrx(sbrx), .sbtx(sbtx), .lane_0_tx_o(l0_tx), .lane_1_tx_o(l1_tx),
        .enable_scr(enable_scr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_read(input logic [7:0] a, output logic [31:0] d);
        c_address = a;
        c_read    = 1'b1;
        tick();
        c_read = 1'b0;
        d      = c_data_out;
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        c_address = a;
        c_data_in = d;
        c_write   = 1'b1;
        tick();
        c_write = 1'b0;
    endtask

    task automatic wait_state(input string tag, input logic [2:0] code, input int budget);
        logic [31:0] d;
        int n;
        n = 0;
        cfg_read(8'h02, d);
        while (d[2:0] !== code && n < budget) begin
            cfg_read(8'h02, d);
            n++;
        end
        check(tag, {29'd0, d[2:0]}, {29'd0, code});
    endtask

    task automatic send_sb(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            sbrx = fr[k];
            repeat (16) tick();
        end
        sbrx = 1'b1;
    endtask

    task automatic send_lane_byte(input logic [7:0] b);
        for (int k = 0; k < 4; k++) begin
            l0_rx        = b[2*k];
            l1_rx        = b[2*k+1];
            enable_deser = 1'b1;
            tick();
        end
        enable_deser = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [9:0]  hs_frame;
        logic [1:0]  ts_pairs [4];
        logic [3:0]  f0_bits;
        int          n;

        hs_frame    = 10'b1_1010_0101_0;   // stop, 0xA5, start (bit 0 sent first)
        ts_pairs[0] = 2'b11;               // {lane0, lane1} for 0x4B
        ts_pairs[1] = 2'b01;
        ts_pairs[2] = 2'b00;
        ts_pairs[3] = 2'b10;
        f0_bits     = 4'b1100;             // bits 0,0,1,1 in time order for 0xF0

        rst = 1'b1; lane_disable = 1'b0; c_read = 1'b0; c_write = 1'b0;
        c_address = 8'd0; c_data_in = 32'd0; tl_in = 8'd0;
        l0_rx = 1'b0; l1_rx = 1'b0; enable_deser = 1'b0; sbrx = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // reset state
        check("rst_sbtx", {31'd0, sbtx}, 32'd0);
        check("rst_lanes", {30'd0, l0_tx, l1_tx}, 32'd0);
        check("rst_scr", {31'd0, enable_scr}, 32'd0);
        check("rst_cdata", c_data_out, 32'd0);
        check("rst_tlout", {24'd0, tl_out}, 32'd0);
        cfg_read(8'h02, d); check("rst_status", d, 32'd0);

        // config map
        cfg_read(8'h00, d); check("cap", d, 32'h7);
        cfg_read(8'h05, d); check("unmapped", d, 32'd0);
        cfg_write(8'h00, 32'h123); cfg_read(8'h00, d); check("cap_ro", d, 32'h7);
        cfg_read(8'h01, d); check("ctrl_rst", d, 32'd0);
        cfg_write(8'h01, 32'h101); cfg_read(8'h01, d); check("ctrl_rb", d, 32'h101);
        cfg_read(8'h02, d); check("st_connect", d, 32'h1);
        check("sbtx_idle", {31'd0, sbtx}, 32'd1);
        c_address = 8'h01; c_data_in = 32'h1; c_read = 1'b1; c_write = 1'b1;
        tick();
        c_read = 1'b0; c_write = 1'b0;
        check("rw_same_old", c_data_out, 32'h101);
        cfg_read(8'h01, d); check("rw_same_new", d, 32'h1);

        // sideband connect, then watch the handshake frame on sbtx
        sbrx = 1'b1;
        n = 0;
        while (sbtx !== 1'b0 && n < 100) begin tick(); n++; end
        check("hs_start_seen", {31'd0, sbtx}, 32'd0);
        repeat (8) tick();
        for (int k = 0; k < 10; k++) begin
            check($sformatf("hs_bit%0d", k), {31'd0, sbtx}, {31'd0, hs_frame[k]});
            if (k < 9) repeat (16) tick();
        end
        cfg_read(8'h02, d); check("st_handshake", d, 32'h2);

        // partner handshake, then TS pattern on the lanes
        send_sb(8'hA5);
        wait_state("st_training", 3'd3, 400);
        n = 0;
        while (!(l0_tx === 1'b1 && l1_tx === 1'b1) && n < 16) begin tick(); n++; end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("ts_pair%0d", k), {30'd0, l0_tx, l1_tx}, {30'd0, ts_pairs[k]});
            tick();
        end

        // eight received TS bytes complete training
        for (int k = 0; k < 8; k++) send_lane_byte(8'h4B);
        wait_state("st_cl0", 3'd4, 40);
        check("cl0_scr", {31'd0, enable_scr}, 32'd1);
        check("tlout_held_train", {24'd0, tl_out}, 32'd0);
        cfg_read(8'h02, d); check("status_cl0", d, 32'h44);

        // CL0 receive path
        send_lane_byte(8'h3C);
        tick(); tick();
        check("rx_3c", {24'd0, tl_out}, 32'h3C);
        send_lane_byte(8'hC3);
        tick(); tick();
        check("rx_c3", {24'd0, tl_out}, 32'hC3);

        // CL0 transmit path
        tl_in = 8'hF0;
        repeat (8) tick();
        n = 0;
        while (l0_tx !== 1'b1 && n < 8) begin tick(); n++; end
        n = 0;
        while (l0_tx !== 1'b0 && n < 8) begin tick(); n++; end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("f0_l0_%0d", k), {31'd0, l0_tx}, {31'd0, f0_bits[k]});
            check($sformatf("f0_l1_%0d", k), {31'd0, l1_tx}, {31'd0, f0_bits[k]});
            tick();
        end

        // lane_disable in CL0
        lane_disable = 1'b1;
        tick();
        check("dis_sbtx", {31'd0, sbtx}, 32'd0);
        check("dis_scr", {31'd0, enable_scr}, 32'd0);
        cfg_read(8'h02, d); check("dis_state", {29'd0, d[2:0]}, 32'd0);
        check("dis_tlout_kept", {24'd0, tl_out}, 32'hC3);

        // back up to TRAINING, then sideband disconnect
        lane_disable = 1'b0;
        wait_state("re_connect", 3'd1, 10);
        wait_state("re_handshake", 3'd2, 60);
        send_sb(8'hA5);
        wait_state("re_training", 3'd3, 400);
        sbrx = 1'b0;
        repeat (200) tick();
        cfg_read(8'h02, d); check("disc_early", {29'd0, d[2:0]}, 32'd3);
        repeat (70) tick();
        cfg_read(8'h02, d); check("disc_connect", {29'd0, d[2:0]}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
